// File: rtl/reservation_station_pkg.sv
// Shared sizing defaults and internal opcode encodings used by the integer issue path.
// Opcode 0 is reserved as the idle marker on the ALU operand bundle.
package reservation_station_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int ROB_W_DEF   = 6;
    localparam int OPC_W       = 6;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'd3;
    localparam logic [OPC_W-1:0] OP_AND  = 6'd4;
    localparam logic [OPC_W-1:0] OP_OR   = 6'd5;
    localparam logic [OPC_W-1:0] OP_XOR  = 6'd6;
    localparam logic [OPC_W-1:0] OP_SLT  = 6'd7;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'd8;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'd9;

endpackage

// File: rtl/reservation_station_priority_encoder.sv
// Lowest-set-bit finder; purely combinational, no handshake.
// found is low and idx is 0 when the input vector is empty.
module rs_priority_encoder #(
    parameter int W     = 8,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top so the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Integer reservation station: buffers dispatched ops, snoops both CDBs, issues one ready op per cycle.
// Latency: ready dispatch at edge k issues after edge k+1; rs_full blocks dispatch, rdy_in low freezes all state.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              disp_valid,
    input  logic [OPC_W-1:0]  disp_opcode,
    input  logic [31:0]       disp_vj,
    input  logic [31:0]       disp_vk,
    input  logic              disp_qj_dep,
    input  logic              disp_qk_dep,
    input  logic [ROB_W-1:0]  disp_qj,
    input  logic [ROB_W-1:0]  disp_qk,
    input  logic [31:0]       disp_imm,
    input  logic [31:0]       disp_pc,
    input  logic [ROB_W-1:0]  disp_rob,
    output logic              rs_full,
    input  logic              alu_cdb_valid,
    input  logic [ROB_W-1:0]  alu_cdb_rob,
    input  logic [31:0]       alu_cdb_res,
    input  logic              lsb_cdb_valid,
    input  logic [ROB_W-1:0]  lsb_cdb_rob,
    input  logic [31:0]       lsb_cdb_res,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [31:0]       out_val1,
    output logic [31:0]       out_val2,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_pc,
    output logic [ROB_W-1:0]  out_rob
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_dep;
    logic [RS_SIZE-1:0] qk_dep;
    logic [OPC_W-1:0]   opcode_q [RS_SIZE];
    logic [31:0]        vj_q     [RS_SIZE];
    logic [31:0]        vk_q     [RS_SIZE];
    logic [31:0]        imm_q    [RS_SIZE];
    logic [31:0]        pc_q     [RS_SIZE];
    logic [ROB_W-1:0]   qj_q     [RS_SIZE];
    logic [ROB_W-1:0]   qk_q     [RS_SIZE];
    logic [ROB_W-1:0]   rob_q    [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   iss_idx;
    logic               free_found;
    logic               iss_found;
    logic               disp_accept;

    logic [31:0]        cap_vj;
    logic [31:0]        cap_vk;
    logic               cap_qj_dep;
    logic               cap_qk_dep;

    assign rs_full     = &busy;
    assign ready       = busy & ~qj_dep & ~qk_dep;
    assign disp_accept = disp_valid && free_found;

    rs_priority_encoder #(.W(RS_SIZE), .IDX_W(IDX_W)) u_alloc (
        .vec   (~busy),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_encoder #(.W(RS_SIZE), .IDX_W(IDX_W)) u_select (
        .vec   (ready),
        .idx   (iss_idx),
        .found (iss_found)
    );

    // Operands produced in the dispatch cycle would otherwise miss their only broadcast.
    always_comb begin
        cap_vj     = disp_vj;
        cap_qj_dep = disp_qj_dep;
        if (disp_qj_dep && alu_cdb_valid && (alu_cdb_rob == disp_qj)) begin
            cap_vj     = alu_cdb_res;
            cap_qj_dep = 1'b0;
        end else if (disp_qj_dep && lsb_cdb_valid && (lsb_cdb_rob == disp_qj)) begin
            cap_vj     = lsb_cdb_res;
            cap_qj_dep = 1'b0;
        end

        cap_vk     = disp_vk;
        cap_qk_dep = disp_qk_dep;
        if (disp_qk_dep && alu_cdb_valid && (alu_cdb_rob == disp_qk)) begin
            cap_vk     = alu_cdb_res;
            cap_qk_dep = 1'b0;
        end else if (disp_qk_dep && lsb_cdb_valid && (lsb_cdb_rob == disp_qk)) begin
            cap_vk     = lsb_cdb_res;
            cap_qk_dep = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy   <= '0;
            qj_dep <= '0;
            qk_dep <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                opcode_q[i] <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
                imm_q[i]    <= '0;
                pc_q[i]     <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                rob_q[i]    <= '0;
            end
            out_opcode <= '0;
            out_val1   <= '0;
            out_val2   <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            out_rob    <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy       <= '0;
                out_opcode <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qj_dep[i]) begin
                        if (alu_cdb_valid && (alu_cdb_rob == qj_q[i])) begin
                            vj_q[i]   <= alu_cdb_res;
                            qj_dep[i] <= 1'b0;
                        end else if (lsb_cdb_valid && (lsb_cdb_rob == qj_q[i])) begin
                            vj_q[i]   <= lsb_cdb_res;
                            qj_dep[i] <= 1'b0;
                        end
                    end
                    if (busy[i] && qk_dep[i]) begin
                        if (alu_cdb_valid && (alu_cdb_rob == qk_q[i])) begin
                            vk_q[i]   <= alu_cdb_res;
                            qk_dep[i] <= 1'b0;
                        end else if (lsb_cdb_valid && (lsb_cdb_rob == qk_q[i])) begin
                            vk_q[i]   <= lsb_cdb_res;
                            qk_dep[i] <= 1'b0;
                        end
                    end
                end

                if (iss_found) begin
                    out_opcode    <= opcode_q[iss_idx];
                    out_val1      <= vj_q[iss_idx];
                    out_val2      <= vk_q[iss_idx];
                    out_imm       <= imm_q[iss_idx];
                    out_pc        <= pc_q[iss_idx];
                    out_rob       <= rob_q[iss_idx];
                    busy[iss_idx] <= 1'b0;
                end else begin
                    out_opcode <= '0;
                end

                // The free slot comes from pre-edge busy, so it never collides with the issued slot.
                if (disp_accept) begin
                    busy[free_idx]     <= 1'b1;
                    opcode_q[free_idx] <= disp_opcode;
                    vj_q[free_idx]     <= cap_vj;
                    vk_q[free_idx]     <= cap_vk;
                    qj_dep[free_idx]   <= cap_qj_dep;
                    qk_dep[free_idx]   <= cap_qk_dep;
                    qj_q[free_idx]     <= disp_qj;
                    qk_q[free_idx]     <= disp_qk;
                    imm_q[free_idx]    <= disp_imm;
                    pc_q[free_idx]     <= disp_pc;
                    rob_q[free_idx]    <= disp_rob;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboarded bench: a slot-array reference model predicts each issue; a negedge monitor checks it.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        disp_valid = 1'b0;
    logic [5:0]  disp_opcode = '0;
    logic [31:0] disp_vj = '0, disp_vk = '0, disp_imm = '0, disp_pc = '0;
    logic        disp_qj_dep = 1'b0, disp_qk_dep = 1'b0;
    logic [5:0]  disp_qj = '0, disp_qk = '0, disp_rob = '0;
    logic        rs_full;
    logic        alu_cdb_valid = 1'b0, lsb_cdb_valid = 1'b0;
    logic [5:0]  alu_cdb_rob = '0, lsb_cdb_rob = '0;
    logic [31:0] alu_cdb_res = '0, lsb_cdb_res = '0;
    logic [5:0]  out_opcode;
    logic [31:0] out_val1, out_val2, out_imm, out_pc;
    logic [5:0]  out_rob;

    always #5 clk_in = ~clk_in;

    reservation_station #(.RS_SIZE(N), .ROB_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_opcode(disp_opcode),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_dep(disp_qj_dep), .disp_qk_dep(disp_qk_dep),
        .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob(disp_rob),
        .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_res(alu_cdb_res),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_res(lsb_cdb_res),
        .out_opcode(out_opcode), .out_val1(out_val1), .out_val2(out_val2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob(out_rob)
    );

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        bit          jd, kd;
        logic [5:0]  qj, qk, rob;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [5:0]  rob;
    } exp_t;

    ent_t m [N];
    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   full_disp_seen = 0;
    bit   edge_active = 1'b0;
    logic [5:0]  p_op, p_rob;
    logic [31:0] p_v1, p_v2, p_imm, p_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    function automatic bit model_full();
        for (int i = 0; i < N; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit cdb_lookup(input logic [5:0] tag, output logic [31:0] val);
        val = '0;
        if (alu_cdb_valid && alu_cdb_rob == tag) begin val = alu_cdb_res; return 1'b1; end
        if (lsb_cdb_valid && lsb_cdb_rob == tag) begin val = lsb_cdb_res; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m[i].busy = 1'b0; m[i].op = '0; m[i].vj = '0; m[i].vk = '0; m[i].imm = '0;
            m[i].pc = '0; m[i].jd = 1'b0; m[i].kd = 1'b0; m[i].qj = '0; m[i].qk = '0; m[i].rob = '0;
        end
        sb.delete();
    endtask

    // Applies one clock edge worth of rules to the reference slots using the currently driven inputs.
    task automatic model_eval();
        int sel;
        int fr;
        logic [31:0] v;
        exp_t e;
        if (!rst_in || !rdy_in) return;
        if (clear_in) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            return;
        end
        sel = -1;
        fr  = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i].busy && !m[i].jd && !m[i].kd) sel = i;
            if (!m[i].busy) fr = i;
        end
        for (int i = 0; i < N; i++) begin
            if (m[i].busy && m[i].jd && cdb_lookup(m[i].qj, v)) begin m[i].vj = v; m[i].jd = 1'b0; end
            if (m[i].busy && m[i].kd && cdb_lookup(m[i].qk, v)) begin m[i].vk = v; m[i].kd = 1'b0; end
        end
        if (sel >= 0) begin
            e.cyc = cyc_cnt + 1;
            e.op = m[sel].op; e.v1 = m[sel].vj; e.v2 = m[sel].vk;
            e.imm = m[sel].imm; e.pc = m[sel].pc; e.rob = m[sel].rob;
            sb.push_back(e);
            m[sel].busy = 1'b0;
        end
        if (disp_valid && fr >= 0) begin
            m[fr].busy = 1'b1; m[fr].op = disp_opcode; m[fr].imm = disp_imm;
            m[fr].pc = disp_pc; m[fr].rob = disp_rob; m[fr].qj = disp_qj; m[fr].qk = disp_qk;
            m[fr].vj = disp_vj; m[fr].jd = disp_qj_dep;
            m[fr].vk = disp_vk; m[fr].kd = disp_qk_dep;
            if (disp_qj_dep && cdb_lookup(disp_qj, v)) begin m[fr].vj = v; m[fr].jd = 1'b0; end
            if (disp_qk_dep && cdb_lookup(disp_qk, v)) begin m[fr].vk = v; m[fr].kd = 1'b0; end
        end
    endtask

    always @(posedge clk_in) begin
        edge_active = rst_in && rdy_in;
        cyc_cnt++;
    end

    // Monitor: pops an expectation whenever an issue appears after an active edge.
    always @(negedge clk_in) begin
        chk("rs_full", 32'(rs_full), 32'(model_full()));
        if (rst_in && !edge_active) begin
            chk("hold_opcode", 32'(out_opcode), 32'(p_op));
            chk("hold_val1", out_val1, p_v1);
            chk("hold_val2", out_val2, p_v2);
            chk("hold_rob", 32'(out_rob), 32'(p_rob));
        end else if (rst_in && edge_active) begin
            if (out_opcode != 6'd0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got opcode %0d rob %0d want idle (cycle %0d)",
                             out_opcode, out_rob, cyc_cnt);
                end else begin
                    mon_e = sb.pop_front();
                    chk("issue_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
                    chk("out_opcode", 32'(out_opcode), 32'(mon_e.op));
                    chk("out_val1", out_val1, mon_e.v1);
                    chk("out_val2", out_val2, mon_e.v2);
                    chk("out_imm", out_imm, mon_e.imm);
                    chk("out_pc", out_pc, mon_e.pc);
                    chk("out_rob", 32'(out_rob), 32'(mon_e.rob));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
                checks++; errors++;
                $display("FAIL missing_issue: got idle want rob %0d (cycle %0d)", sb[0].rob, cyc_cnt);
                void'(sb.pop_front());
            end
        end
        p_op = out_opcode; p_v1 = out_val1; p_v2 = out_val2;
        p_imm = out_imm; p_pc = out_pc; p_rob = out_rob;
    end

    task automatic cyc();
        @(negedge clk_in);
        #1;
        if (rst_in && rdy_in && !clear_in && disp_valid && rs_full) full_disp_seen++;
        model_eval();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_in();
        disp_valid = 1'b0; alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0; clear_in = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic jd, input logic [5:0] qj, input logic kd, input logic [5:0] qk,
                        input logic [31:0] imm, input logic [5:0] rob);
        disp_valid = 1'b1; disp_opcode = op; disp_vj = vj; disp_vk = vk;
        disp_qj_dep = jd; disp_qj = qj; disp_qk_dep = kd; disp_qk = qk;
        disp_imm = imm; disp_pc = $urandom; disp_rob = rob;
    endtask

    task automatic alu_bc(input logic [5:0] tag, input logic [31:0] res);
        alu_cdb_valid = 1'b1; alu_cdb_rob = tag; alu_cdb_res = res;
    endtask

    initial begin
        int seen0;
        int t;
        model_reset();
        #1 rst_in = 1'b0;
        #2;
        chk("reset_opcode", 32'(out_opcode), 32'd0);
        chk("reset_full", 32'(rs_full), 32'd0);
        cyc(); cyc();
        rst_in = 1'b1;
        cyc();

        // Ready ADDI: issued one edge after dispatch, then idle.
        disp(OP_ADDI, 32'd5, 32'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd3, 6'd2);
        cyc(); idle_in();
        cyc();
        chk("addi_opcode", 32'(out_opcode), 32'(OP_ADDI));
        chk("addi_val1", out_val1, 32'd5);
        chk("addi_imm", out_imm, 32'd3);
        chk("addi_rob", 32'(out_rob), 32'd2);
        cyc();
        chk("addi_idle", 32'(out_opcode), 32'd0);
        chk("addi_notfull", 32'(rs_full), 32'd0);

        // Wakeup through the ALU broadcast.
        disp(OP_ADD, 32'd0, 32'd7, 1'b1, 6'd3, 1'b0, 6'd0, 32'd0, 6'd4);
        cyc(); idle_in();
        cyc(); cyc();
        alu_bc(6'd3, 32'h10);
        cyc(); idle_in();
        chk("wake_not_early", 32'(out_opcode), 32'd0);
        cyc();
        chk("wake_opcode", 32'(out_opcode), 32'(OP_ADD));
        chk("wake_val1", out_val1, 32'h10);
        chk("wake_val2", out_val2, 32'd7);

        // Same-cycle capture from the LSB broadcast.
        disp(OP_SUB, 32'd9, 32'd0, 1'b0, 6'd0, 1'b1, 6'd4, 32'd0, 6'd5);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 6'd4; lsb_cdb_res = 32'hDEADBEEF;
        cyc(); idle_in();
        cyc();
        chk("capture_val2", out_val2, 32'hDEADBEEF);

        // Fill all slots, try an overflow dispatch, then release them in slot order.
        for (int i = 0; i < N; i++) begin
            disp(OP_ADD, 32'(i), 32'd0, 1'b1, 6'd9, 1'b0, 6'd0, 32'(i), 6'(10 + i));
            cyc();
        end
        idle_in();
        cyc();
        chk("full_set", 32'(rs_full), 32'd1);
        seen0 = full_disp_seen;
        disp(OP_XOR, 32'd1, 32'd1, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 6'd20);
        cyc(); idle_in();
        chk("overflow_seen", 32'(full_disp_seen), 32'(seen0 + 1));
        chk("full_still", 32'(rs_full), 32'd1);
        alu_bc(6'd9, 32'd1);
        cyc(); idle_in();
        for (int i = 0; i < N; i++) begin
            cyc();
            chk("order_rob", 32'(out_rob), 32'(10 + i));
            chk("order_val1", out_val1, 32'd1);
        end
        cyc();
        chk("drained_full", 32'(rs_full), 32'd0);

        // Flush with three waiting entries and one that would issue at the flush edge.
        for (int i = 0; i < 3; i++) begin
            disp(OP_AND, 32'd0, 32'd0, 1'b1, 6'd12, 1'b0, 6'd0, 32'd0, 6'(30 + i));
            cyc();
        end
        disp(OP_OR, 32'd1, 32'd2, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 6'd33);
        cyc(); idle_in();
        clear_in = 1'b1;
        disp(OP_SUB, 32'd1, 32'd2, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 6'd34);
        cyc(); idle_in();
        chk("flush_opcode", 32'(out_opcode), 32'd0);
        alu_bc(6'd12, 32'h55);
        cyc(); idle_in();
        cyc(); cyc();
        chk("flush_no_issue", 32'(out_opcode), 32'd0);

        // Freeze: pending ready entry must wait, and a frozen dispatch is dropped.
        disp(OP_OR, 32'hAA, 32'h55, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 6'd40);
        cyc(); idle_in();
        rdy_in = 1'b0;
        disp(OP_XOR, 32'd3, 32'd3, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 6'd41);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("freeze_idle", 32'(out_opcode), 32'd0);
        end
        idle_in();
        rdy_in = 1'b1;
        cyc();
        chk("unfreeze_opcode", 32'(out_opcode), 32'(OP_OR));
        chk("unfreeze_rob", 32'(out_rob), 32'd40);
        rdy_in = 1'b0;
        cyc(); cyc();
        chk("freeze_held", 32'(out_opcode), 32'(OP_OR));
        rdy_in = 1'b1;
        cyc();

        // Asynchronous reset in the middle of an issue.
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 32'd0, 32'd0, 1'b1, 6'd2, 1'b0, 6'd0, 32'd0, 6'(45 + i));
            cyc();
        end
        disp(OP_AND, 32'd1, 32'd2, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 6'd50);
        cyc(); idle_in();
        cyc();
        chk("pre_reset_opcode", 32'(out_opcode), 32'(OP_AND));
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        chk("async_reset_opcode", 32'(out_opcode), 32'd0);
        chk("async_reset_full", 32'(rs_full), 32'd0);
        model_reset();
        cyc(); cyc();
        rst_in = 1'b1;
        disp(OP_ADD, 32'd0, 32'd0, 1'b1, 6'd2, 1'b0, 6'd0, 32'd0, 6'd1);
        cyc();
        disp(OP_SUB, 32'd0, 32'd0, 1'b1, 6'd2, 1'b0, 6'd0, 32'd0, 6'd2);
        cyc(); idle_in();
        alu_bc(6'd2, 32'h77);
        cyc(); idle_in();
        cyc();
        chk("post_reset_first", 32'(out_rob), 32'd1);
        cyc();
        chk("post_reset_second", 32'(out_rob), 32'd2);
        cyc();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            rdy_in   = ($urandom_range(0, 19) != 0);
            clear_in = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) != 0)
                disp(6'($urandom_range(1, 9)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                     $urandom, 6'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0)
                alu_bc(6'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                t = $urandom_range(0, 7);
                if (alu_cdb_valid && 6'(t) == alu_cdb_rob) t = (t + 1) % 8;
                lsb_cdb_valid = 1'b1; lsb_cdb_rob = 6'(t); lsb_cdb_res = $urandom;
            end
            cyc();
        end

        // Drain: wake every tag the random phase could have used.
        idle_in();
        rdy_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu_bc(6'(i), $urandom);
            cyc();
        end
        idle_in();
        for (int i = 0; i < 20; i++) cyc();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("final_not_full", 32'(rs_full), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue-side counterpart of the integer ALU in the Tomasulo core.
- Buffers decoded integer/branch instructions until both source operands are available.
- Snoops the ALU and LSB result broadcasts (CDB) to resolve pending operands, then issues one ready instruction per cycle as a registered operand bundle that directly drives the combinational ALU.
- Sits between dispatch (decoder/ROB) and the ALU.

Parameters:
- RS_SIZE, 8: number of entries (power of two, 2..16).
- ROB_W, 6: ROB index width; matches the ALU rob_index width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes all state.
- clear_in  input  1  misprediction flush; synchronous.
- disp_valid  input  1  dispatch request.
- disp_opcode  input  6  internal opcode; 0 is illegal here.
- disp_vj, disp_vk  input  32  operand values, valid when the matching dependency flag is 0.
- disp_qj_dep, disp_qk_dep  input  1  operand still pending in the ROB.
- disp_qj, disp_qk  input  ROB_W  producing ROB index.
- disp_imm, disp_pc  input  32  immediate and instruction PC.
- disp_rob  input  ROB_W  destination ROB index.
- rs_full  output  1  no free entry (combinational from busy bits).
- alu_cdb_valid, lsb_cdb_valid  input  1  broadcast strobes.
- alu_cdb_rob, lsb_cdb_rob  input  ROB_W  broadcast tags.
- alu_cdb_res, lsb_cdb_res  input  32  broadcast values.
- out_opcode  output  6  to ALU; 0 means idle (ALU valid = opcode != 0).
- out_val1, out_val2, out_imm, out_pc  output  32  to ALU.
- out_rob  output  ROB_W  to ALU.

Behaviour:
- Entry fields: busy, opcode, vj, vk, qj_dep, qk_dep, qj, qk, imm, pc, rob.
- Reset (rst_in low, async): all busy = 0; all out_* = 0; rs_full = 0.
- Priority per rising edge: reset > rdy_in low (hold everything) > clear_in > normal.
- clear_in high: all busy cleared and out_opcode <= 0. Dispatch and broadcasts in the same cycle are discarded.
- Dispatch: accepted when disp_valid && !rs_full. Written into the lowest-index free entry.
  - disp_valid while rs_full: ignored, state unchanged. A bench assertion flags it.
  - An issue freeing a slot in the same cycle does not make room for that cycle's dispatch.
- Same-cycle capture at dispatch: if disp_qj_dep and a valid CDB tag equals disp_qj, store that CDB result in vj and clear qj_dep (likewise k). ALU port is checked before LSB; a matching tag on both ports is a protocol error.
- Wakeup: every busy entry with qX_dep whose qX equals a valid CDB tag latches the result and clears qX_dep. Both ports are applied in the same cycle.
- Select: the lowest-index busy entry with qj_dep == 0 && qk_dep == 0, evaluated on pre-edge state.
  - An entry dispatched or woken at edge k is eligible from cycle k+1.
- Issue: the selected entry's fields are registered into out_* (out_val1 = vj, out_val2 = vk) and busy is cleared at the same edge.
  - No ready entry: out_opcode <= 0; other out_* are don't-care but are held.
  - Throughput: one issue per cycle.
- Latency: dispatch with both operands ready at edge k → out_* valid after edge k+1.
- Wakeup edge case: a CDB broadcast at edge k for an entry already selected at k is impossible (a selected entry has no dependencies).
- Wrap-around: none. Slot allocation is by priority encoder, so freed slots are reused immediately.

Decomposition:
- const.v holds RS_SIZE, ROB_W and all opcode defines, shared with the ALU, decoder and ROB.
- One sub-module: rs_priority_encoder, parameterised by width. Given a bit vector it returns the lowest set index plus a found flag.
  - Instance 1 on ~busy: free-slot allocation.
  - Instance 2 on busy & ~qj_dep & ~qk_dep: issue selection.

Test Plan:
- Ready issue: dispatch ADDI, vj=5, imm=3, rob=2, no deps at edge 1 → after edge 2: out_opcode=ADDI, out_val1=5, out_imm=3, out_rob=2. After edge 3: out_opcode=0, rs_full=0.
- Wakeup: dispatch ADD, qj_dep=1, qj=3, vk=7. Hold alu_cdb rob=3, res=0x10 at edge 4 → issue after edge 5 with out_val1=0x10, out_val2=7. No issue earlier.
- Dispatch-capture: dispatch SUB, qk_dep=1, qk=4, while lsb_cdb rob=4, res=0xDEADBEEF is valid in the same cycle → after the next edge out_val2=0xDEADBEEF.
- Full/order: dispatch 8 entries all waiting on rob=9 → rs_full=1, and a 9th dispatch is ignored. Broadcast rob=9, res=1 → 8 consecutive issues in entry order 0..7, then rs_full=0.
- Flush/freeze: with 3 busy entries, clear_in for one cycle → busy all 0 and out_opcode=0. With rdy_in=0 and a ready entry pending → no issue and outputs held until rdy_in=1.
- Reset: drive rst_in low mid-issue between clock edges → out_opcode=0 and rs_full=0 immediately. After release, the first dispatch lands in entry 0.
